// File: rtl/spram_fifo_sched_pkg.sv
// Shared types and constants for the SPRAM FIFO scheduler: FSM states,
// SPRAM word width and write-mask values.
package spram_fifo_sched_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } sched_state_t;

    localparam int         RAM_DATA_W   = 16;
    localparam logic [3:0] RAM_MASK_ALL = 4'b1111;

    // One byte per SPRAM word, stored in the low byte.
    function automatic logic [RAM_DATA_W-1:0] ram_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/spram_fifo_sched.sv
// Shares one single-port SPRAM between a byte writer and a byte reader.
// Writes always win; reads prefetch into a one-byte output register.
module spram_fifo_sched
    import spram_fifo_sched_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_strobe,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [RAM_DATA_W-1:0] ram_wdata,
    output logic                  ram_wren,
    output logic [3:0]            ram_maskwren,
    input  logic [RAM_DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]       level,
    output logic                  full,
    output logic                  overflow,
    output sched_state_t          dbg_state
);

    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_pend_v;
    logic [7:0]        r_pend;
    logic              r_rd_valid;
    logic [7:0]        r_rd_data;
    logic              r_overflow;
    sched_state_t      r_state;

    logic w_full;
    logic w_wr_accept;
    logic w_rd_issue;
    logic w_unused_hi;

    assign w_full      = (r_level == LVL_FULL);
    assign w_wr_accept = wr_strobe && !w_full;
    // With pend empty, level counts only committed RAM words.
    assign w_rd_issue  = (r_state == ST_IDLE) && !r_pend_v && !wr_strobe &&
                         (r_level != '0) && (!r_rd_valid || rd_ack);
    assign w_unused_hi = ^ram_rdata[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_pend_v   <= 1'b0;
            r_pend     <= 8'h00;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_overflow <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            if (w_wr_accept) begin
                r_pend   <= wr_data;
                r_pend_v <= 1'b1;
            end else if (r_pend_v) begin
                r_pend_v <= 1'b0;
            end

            if (r_pend_v) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (wr_strobe && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // Issue requires !wr_strobe, so both terms never fire together.
            if (w_wr_accept) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_rd_issue) begin
                r_level <= r_level - LVL_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_issue) begin
                        r_state <= ST_RD_WAIT;
                    end else if (rd_ack && r_rd_valid) begin
                        r_rd_valid <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    r_rd_data  <= ram_rdata[7:0];
                    r_rd_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_wren     = r_pend_v;
    assign ram_addr     = r_pend_v ? r_wr_ptr : r_rd_ptr;
    assign ram_wdata    = ram_word(r_pend);
    assign ram_maskwren = RAM_MASK_ALL;

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign level     = r_level;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spram_fifo_sched.sv
// Directed bench for spram_fifo_sched with ADDR_W=4 and a behavioural SPRAM.
module tb_spram_fifo_sched;
    import spram_fifo_sched_pkg::*;

    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset_n;
    logic [7:0]        wr_data;
    logic              wr_strobe;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_wren;
    logic [3:0]        ram_maskwren;
    logic [15:0]       ram_rdata;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overflow;
    sched_state_t      dbg_state;

    logic [15:0] mem [16];

    int n_pass  = 0;
    int n_total = 0;

    spram_fifo_sched #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ack       (rd_ack),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_maskwren (ram_maskwren),
        .ram_rdata    (ram_rdata),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write or read per edge, read data registered.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        else          ram_rdata     <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_data   = d;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp);
        int n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        check("pop_valid", 32'(rd_valid), 32'd1);
        check("pop_data", 32'(rd_data), 32'(exp));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        wr_data   = 8'h00;
        wr_strobe = 1'b0;
        rd_ack    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_mask", 32'(ram_maskwren), 32'hF);

        // Single byte latency
        push(8'hA5);
        check("t1_wren", 32'(ram_wren), 32'd1);
        check("t1_waddr", 32'(ram_addr), 32'd0);
        check("t1_wdata", 32'(ram_wdata), 32'h00A5);
        check("t1_level", 32'(level), 32'd1);
        tick();
        check("t1_issue_wren", 32'(ram_wren), 32'd0);
        check("t1_issue_addr", 32'(ram_addr), 32'd0);
        tick();
        check("t1_rdwait", 32'(dbg_state), 32'(ST_RD_WAIT));
        check("t1_not_yet", 32'(rd_valid), 32'd0);
        tick();
        check("t1_valid", 32'(rd_valid), 32'd1);
        check("t1_data", 32'(rd_data), 32'hA5);
        check("t1_level0", 32'(level), 32'd0);
        pop(8'hA5);
        check("t1_empty", 32'(rd_valid), 32'd0);

        // Back-to-back strobes
        wr_data   = 8'h01;
        wr_strobe = 1'b1;
        tick();
        check("t2_w0_addr", 32'(ram_addr), 32'd1);
        check("t2_w0_data", 32'(ram_wdata), 32'h0001);
        wr_data = 8'h02;
        tick();
        check("t2_w1_wren", 32'(ram_wren), 32'd1);
        check("t2_w1_addr", 32'(ram_addr), 32'd2);
        wr_data = 8'h03;
        tick();
        wr_strobe = 1'b0;
        check("t2_w2_addr", 32'(ram_addr), 32'd3);
        check("t2_w2_data", 32'(ram_wdata), 32'h0003);
        check("t2_level", 32'(level), 32'd3);
        pop(8'h01);
        pop(8'h02);
        pop(8'h03);
        check("t2_no_drop", 32'(overflow), 32'd0);

        // Fill to full, then one dropped write
        wr_strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h10 + i);
            tick();
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_level16", 32'(level), 32'd16);
        wr_data = 8'hEE;
        tick();
        wr_strobe = 1'b0;
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_level_hold", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop(8'(8'h10 + i));
        end
        check("t3_drained", 32'(rd_valid), 32'd0);
        check("t3_level0", 32'(level), 32'd0);
        check("t3_sticky", 32'(overflow), 32'd1);

        // Write collides with a read-eligible cycle
        push(8'hC1);
        repeat (3) tick();
        push(8'hC2);
        tick();
        check("t4_level1", 32'(level), 32'd1);
        check("t4_head", 32'(rd_data), 32'hC1);
        rd_ack    = 1'b1;
        wr_data   = 8'hC3;
        wr_strobe = 1'b1;
        #1;
        check("t4_no_wren_yet", 32'(ram_wren), 32'd0);
        tick();
        rd_ack    = 1'b0;
        wr_strobe = 1'b0;
        check("t4_acked", 32'(rd_valid), 32'd0);
        check("t4_wren", 32'(ram_wren), 32'd1);
        check("t4_waddr", 32'(ram_addr), 32'd6);
        check("t4_level2", 32'(level), 32'd2);
        check("t4_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("t4_issue_wren", 32'(ram_wren), 32'd0);
        check("t4_issue_addr", 32'(ram_addr), 32'd5);
        tick();
        check("t4_rdwait", 32'(dbg_state), 32'(ST_RD_WAIT));
        tick();
        check("t4_data", 32'(rd_data), 32'hC2);
        pop(8'hC2);
        pop(8'hC3);

        // Pointer wrap across 40 bytes
        for (int i = 0; i < 40; i++) begin
            push(8'(i));
            pop(8'(i));
        end
        check("t5_level0", 32'(level), 32'd0);
        check("t5_empty", 32'(rd_valid), 32'd0);

        // Async reset during RD_WAIT
        push(8'h55);
        tick();
        tick();
        check("t6_rdwait", 32'(dbg_state), 32'(ST_RD_WAIT));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_wren", 32'(ram_wren), 32'd0);
        check("t6_addr", 32'(ram_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        push(8'h77);
        check("t6_wren_after", 32'(ram_wren), 32'd1);
        check("t6_addr_after", 32'(ram_addr), 32'd0);
        pop(8'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
